// File: rtl/sad_mon_pkg.sv
// Shared definitions for the SAD result monitor: FSM state codes, the update
// saturation limit and a saturating 8-bit increment helper.
package sad_mon_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [7:0] UPD_MAX = 8'd255;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    if (value == UPD_MAX) begin
      return value;
    end else begin
      return value + 8'd1;
    end
  endfunction

endpackage

// File: rtl/sad_stall_detect.sv
// Watches the program-counter tap and pulses "stalled" once the PC has compared
// equal to its previous value STALL_LIMIT times in a row (terminal jump-to-self).
module sad_stall_detect
  import sad_mon_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int STALL_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              enable,
  input  logic [DATA_W-1:0] pc_in,
  output logic              stalled
);

  logic [DATA_W-1:0] prev_pc_r;
  logic [7:0]        stall_cnt_r;
  logic              same_s;

  assign same_s  = (pc_in == prev_pc_r);
  // Fires on the comparison that would make the run of equal PCs STALL_LIMIT long.
  assign stalled = enable && same_s && (stall_cnt_r == 8'(STALL_LIMIT - 1));

  // PC history and consecutive-equal counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_pc_r   <= '0;
      stall_cnt_r <= 8'd0;
    end else if (clear) begin
      prev_pc_r   <= pc_in;
      stall_cnt_r <= 8'd0;
    end else if (enable) begin
      prev_pc_r <= pc_in;
      if (!same_s) begin
        stall_cnt_r <= 8'd0;
      end else begin
        stall_cnt_r <= sat_inc8(stall_cnt_r);
      end
    end else begin
      prev_pc_r   <= prev_pc_r;
      stall_cnt_r <= stall_cnt_r;
    end
  end

endmodule

// File: rtl/sad_result_monitor.sv
// Observer for the SAD core: records v0/v1 result updates, tracks the minimum
// SAD, detects completion from a stalled PC or a timeout, and latches results.
module sad_result_monitor
  import sad_mon_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int STALL_LIMIT = 8,
  parameter int TIMEOUT     = 100000,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] v0_in,
  input  logic [DATA_W-1:0] v1_in,
  input  logic [DATA_W-1:0] pc_in,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              upd_valid,
  output logic [DATA_W-1:0] last_v0,
  output logic [DATA_W-1:0] last_v1,
  output logic [DATA_W-1:0] min_v0,
  output logic [DATA_W-1:0] min_v1,
  output logic [7:0]        upd_count,
  output logic [CNT_W-1:0]  cycle_count
);

  logic [1:0]        state_r;
  logic [1:0]        state_next_s;
  logic [DATA_W-1:0] prev_v0_r;
  logic [DATA_W-1:0] prev_v1_r;
  logic              busy_r;
  logic              done_r;
  logic              timeout_r;
  logic              upd_valid_r;
  logic [DATA_W-1:0] last_v0_r;
  logic [DATA_W-1:0] last_v1_r;
  logic [DATA_W-1:0] min_v0_r;
  logic [DATA_W-1:0] min_v1_r;
  logic [7:0]        upd_count_r;
  logic [CNT_W-1:0]  cycle_count_r;

  logic arm_s;
  logic run_s;
  logic record_s;
  logic new_min_s;
  logic tmo_hit_s;
  logic stalled_s;

  sad_stall_detect #(
    .DATA_W      (DATA_W),
    .STALL_LIMIT (STALL_LIMIT)
  ) u_stall (
    .clk     (clk),
    .rst     (rst),
    .clear   (arm_s),
    .enable  (run_s),
    .pc_in   (pc_in),
    .stalled (stalled_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; a stall completion takes priority over the timeout.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) state_next_s = ST_RUN;
        else       state_next_s = state_r;
      end
      ST_RUN: begin
        if (stalled_s || tmo_hit_s) state_next_s = ST_DONE;
        else                        state_next_s = ST_RUN;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Per-state control decode
  always_comb begin
    arm_s = 1'b0;
    run_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        arm_s = start;
        run_s = 1'b0;
      end
      ST_RUN: begin
        arm_s = 1'b0;
        run_s = 1'b1;
      end
      default: begin
        arm_s = 1'b0;
        run_s = 1'b0;
      end
    endcase
    record_s  = run_s && ((v0_in != prev_v0_r) || (v1_in != prev_v1_r));
    new_min_s = (v0_in < min_v0_r);
    tmo_hit_s = run_s && (cycle_count_r == CNT_W'(TIMEOUT - 1));
  end

  // Status flags, registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      upd_valid_r <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      busy_r      <= (state_next_s == ST_RUN);
      done_r      <= (state_next_s == ST_DONE);
      upd_valid_r <= record_s;
      if (arm_s) begin
        timeout_r <= 1'b0;
      end else if (run_s) begin
        timeout_r <= tmo_hit_s && !stalled_s;
      end else begin
        timeout_r <= timeout_r;
      end
    end
  end

  // Cycle / update counters and tap history
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_count_r <= '0;
      upd_count_r   <= 8'd0;
      prev_v0_r     <= '0;
      prev_v1_r     <= '0;
    end else if (arm_s) begin
      cycle_count_r <= '0;
      upd_count_r   <= 8'd0;
      prev_v0_r     <= v0_in;
      prev_v1_r     <= v1_in;
    end else if (run_s) begin
      cycle_count_r <= (cycle_count_r == {CNT_W{1'b1}}) ? cycle_count_r
                                                        : cycle_count_r + CNT_W'(1);
      prev_v0_r     <= v0_in;
      prev_v1_r     <= v1_in;
      if (record_s) upd_count_r <= sat_inc8(upd_count_r);
    end
  end

  // Latched results; strict less-than keeps the first-seen minimum on ties.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_v0_r <= '0;
      last_v1_r <= '0;
      min_v0_r  <= {DATA_W{1'b1}};
      min_v1_r  <= '0;
    end else if (arm_s) begin
      min_v0_r <= {DATA_W{1'b1}};
      min_v1_r <= '0;
    end else if (record_s) begin
      last_v0_r <= v0_in;
      last_v1_r <= v1_in;
      if (new_min_s) begin
        min_v0_r <= v0_in;
        min_v1_r <= v1_in;
      end
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign timeout     = timeout_r;
  assign upd_valid   = upd_valid_r;
  assign last_v0     = last_v0_r;
  assign last_v1     = last_v1_r;
  assign min_v0      = min_v0_r;
  assign min_v1      = min_v1_r;
  assign upd_count   = upd_count_r;
  assign cycle_count = cycle_count_r;

endmodule

// File: tb/tb_sad_result_monitor.sv
// Self-checking bench for sad_result_monitor: table-driven update checks, a
// scoreboard of expected update pulses, and hand-written completion sequences.
module tb_sad_result_monitor;

  typedef struct {
    logic [31:0] v0;
    logic [31:0] v1;
  } exp_t;

  typedef struct {
    logic [31:0] v0;
    logic [31:0] v1;
    logic        pulse;
    logic [7:0]  cnt;
    logic [31:0] mv0;
    logic [31:0] mv1;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] v0, v1, pc;

  logic        busy_a, done_a, tmo_a, upd_a;
  logic [31:0] last_v0_a, last_v1_a, min_v0_a, min_v1_a, cyc_a;
  logic [7:0]  cnt_a;
  logic        busy_b, done_b, tmo_b, upd_b;
  logic [31:0] last_v0_b, last_v1_b, min_v0_b, min_v1_b, cyc_b;
  logic [7:0]  cnt_b;

  int   n_cmp = 0;
  int   n_err = 0;
  bit   model_run = 1'b0;
  bit   sb_en = 1'b1;
  logic [31:0] mprev_v0, mprev_v1;
  exp_t sb_q[$];
  vec_t tab[6];

  always #5 clk = ~clk;

  sad_result_monitor #(.DATA_W(32), .STALL_LIMIT(8), .TIMEOUT(50), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .start(start), .v0_in(v0), .v1_in(v1), .pc_in(pc),
    .busy(busy_a), .done(done_a), .timeout(tmo_a), .upd_valid(upd_a),
    .last_v0(last_v0_a), .last_v1(last_v1_a), .min_v0(min_v0_a), .min_v1(min_v1_a),
    .upd_count(cnt_a), .cycle_count(cyc_a)
  );

  sad_result_monitor #(.DATA_W(32), .STALL_LIMIT(8), .TIMEOUT(1000), .CNT_W(32)) dut_b (
    .clk(clk), .rst(rst), .start(start), .v0_in(v0), .v1_in(v1), .pc_in(pc),
    .busy(busy_b), .done(done_b), .timeout(tmo_b), .upd_valid(upd_b),
    .last_v0(last_v0_b), .last_v1(last_v1_b), .min_v0(min_v0_b), .min_v1(min_v1_b),
    .upd_count(cnt_b), .cycle_count(cyc_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic sb_check();
    exp_t e;
    if (sb_en && upd_a) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected_pulse: got upd_valid=1, want 0 (last_v0=0x%0h)", last_v0_a);
      end else begin
        e = sb_q.pop_front();
        chk("sb_last_v0", last_v0_a, e.v0);
        chk("sb_last_v1", last_v1_a, e.v1);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    sb_check();
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] p);
    exp_t e;
    v0 = a;
    v1 = b;
    pc = p;
    if (model_run && sb_en && ((a != mprev_v0) || (b != mprev_v1))) begin
      e.v0 = a;
      e.v1 = b;
      sb_q.push_back(e);
    end
    mprev_v0 = a;
    mprev_v1 = b;
  endtask

  task automatic arm();
    start = 1'b1;
    mprev_v0 = v0;
    mprev_v1 = v1;
    tick();
    start = 1'b0;
    model_run = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_run = 1'b0;
    sb_q.delete();
    @(posedge clk);
    #2;
    rst = 1'b1;
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; v0 = 32'd0; v1 = 32'd0; pc = 32'd0;
    mprev_v0 = 32'd0; mprev_v1 = 32'd0;

    tab[0] = '{32'd0,  32'd0, 1'b0, 8'd0, 32'hFFFF_FFFF, 32'd0};
    tab[1] = '{32'd0,  32'd0, 1'b0, 8'd0, 32'hFFFF_FFFF, 32'd0};
    tab[2] = '{32'd40, 32'd1, 1'b1, 8'd1, 32'd40,        32'd1};
    tab[3] = '{32'd25, 32'd2, 1'b1, 8'd2, 32'd25,        32'd2};
    tab[4] = '{32'd25, 32'd2, 1'b0, 8'd2, 32'd25,        32'd2};
    tab[5] = '{32'd30, 32'd3, 1'b1, 8'd3, 32'd25,        32'd2};

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy", busy_a, 32'd0);
    chk("rst_done", done_a, 32'd0);
    chk("rst_timeout", tmo_a, 32'd0);
    chk("rst_upd_valid", upd_a, 32'd0);
    chk("rst_upd_count", cnt_a, 32'd0);
    chk("rst_cycle_count", cyc_a, 32'd0);
    chk("rst_last_v0", last_v0_a, 32'd0);
    chk("rst_min_v0", min_v0_a, 32'hFFFF_FFFF);
    chk("rst_min_v1", min_v1_a, 32'd0);
    rst = 1'b1;

    // Reset asserted mid-run aborts immediately
    drive(32'd0, 32'd0, 32'd0);
    arm();
    chk("arm_busy", busy_a, 32'd1);
    for (int i = 1; i <= 5; i++) begin
      drive(32'd0, 32'd0, 32'(4 * i));
      tick();
    end
    drive(32'd9, 32'd0, 32'd24);
    rst = 1'b0;
    #1;
    chk("midrst_busy", busy_a, 32'd0);
    chk("midrst_done", done_a, 32'd0);
    chk("midrst_upd_count", cnt_a, 32'd0);
    chk("midrst_min_v0", min_v0_a, 32'hFFFF_FFFF);
    model_run = 1'b0;
    sb_q.delete();
    #9;
    rst = 1'b1;

    // Update sequence, table-driven
    drive(32'd0, 32'd0, 32'd0);
    arm();
    for (int i = 0; i < 6; i++) begin
      drive(tab[i].v0, tab[i].v1, 32'(4 * (i + 1)));
      tick();
      chk($sformatf("tab%0d_upd_valid", i), upd_a, tab[i].pulse);
      chk($sformatf("tab%0d_upd_count", i), cnt_a, tab[i].cnt);
      chk($sformatf("tab%0d_min_v0", i), min_v0_a, tab[i].mv0);
      chk($sformatf("tab%0d_min_v1", i), min_v1_a, tab[i].mv1);
    end
    chk("upd_last_v0", last_v0_a, 32'd30);
    chk("upd_last_v1", last_v1_a, 32'd3);
    chk("upd_sb_drained", sb_q.size(), 32'd0);
    do_reset();

    // Completion by stall, with a tap change on the completing edge
    drive(32'd0, 32'd0, 32'h0000_00B0);
    arm();
    for (int i = 1; i <= 28; i++) begin
      drive((i == 28) ? 32'd7 : 32'd0, 32'd0, (i <= 20) ? 32'(32'hB0 + 4 * i) : 32'h0000_0100);
      tick();
      if (i >= 20) chk($sformatf("stall_done_c%0d", i), done_a, (i == 28) ? 32'd1 : 32'd0);
    end
    model_run = 1'b0;
    chk("stall_timeout", tmo_a, 32'd0);
    chk("stall_busy", busy_a, 32'd0);
    chk("stall_cycle_count", cyc_a, 32'd28);
    chk("stall_upd_count", cnt_a, 32'd1);
    chk("stall_min_v0", min_v0_a, 32'd7);
    for (int i = 0; i < 3; i++) begin
      drive(32'd123, 32'd9, 32'h0000_0100);
      tick();
    end
    chk("frozen_last_v0", last_v0_a, 32'd7);
    chk("frozen_upd_count", cnt_a, 32'd1);
    chk("frozen_cycle_count", cyc_a, 32'd28);
    chk("frozen_done", done_a, 32'd1);
    chk("stall_sb_drained", sb_q.size(), 32'd0);
    do_reset();

    // Interrupted stall: 6 equal, change, then 8 equal
    drive(32'd0, 32'd0, 32'h0000_0200);
    arm();
    for (int i = 1; i <= 15; i++) begin
      drive(32'd0, 32'd0, (i <= 6) ? 32'h0000_0200 : 32'h0000_0300);
      tick();
      chk($sformatf("intr_done_c%0d", i), done_a, (i == 15) ? 32'd1 : 32'd0);
    end
    model_run = 1'b0;
    do_reset();

    // Timeout (TIMEOUT=50), with two updates along the way
    drive(32'd0, 32'd0, 32'd0);
    arm();
    for (int i = 1; i <= 50; i++) begin
      drive((i == 10) ? 32'd5 : 32'd0, 32'd0, 32'(4 * i));
      tick();
      if (i >= 49) chk($sformatf("tmo_done_c%0d", i), done_a, (i == 50) ? 32'd1 : 32'd0);
    end
    model_run = 1'b0;
    chk("tmo_timeout", tmo_a, 32'd1);
    chk("tmo_cycle_count", cyc_a, 32'd50);
    chk("tmo_busy", busy_a, 32'd0);
    chk("tmo_upd_count", cnt_a, 32'd2);
    chk("tmo_min_v0", min_v0_a, 32'd0);

    // Re-arm from DONE
    drive(32'd0, 32'd0, 32'd0);
    arm();
    chk("rearm_busy", busy_a, 32'd1);
    chk("rearm_done", done_a, 32'd0);
    chk("rearm_timeout", tmo_a, 32'd0);
    chk("rearm_cycle_count", cyc_a, 32'd0);
    chk("rearm_upd_count", cnt_a, 32'd0);
    chk("rearm_min_v0", min_v0_a, 32'hFFFF_FFFF);

    // Stall completing on the timeout cycle: stall wins
    for (int i = 1; i <= 50; i++) begin
      drive(32'd0, 32'd0, (i <= 42) ? 32'(4 * i) : 32'd168);
      tick();
      if (i >= 49) chk($sformatf("coinc_done_c%0d", i), done_a, (i == 50) ? 32'd1 : 32'd0);
    end
    model_run = 1'b0;
    chk("coinc_timeout", tmo_a, 32'd0);
    chk("coinc_cycle_count", cyc_a, 32'd50);
    chk("coinc_sb_drained", sb_q.size(), 32'd0);
    do_reset();

    // Update counter saturation on the long-timeout instance
    sb_en = 1'b0;
    drive(32'd0, 32'd0, 32'd0);
    arm();
    for (int i = 1; i <= 300; i++) begin
      drive(32'(i % 2), 32'd0, 32'(4 * i));
      tick();
      if (i == 254) chk("sat_cnt_254", cnt_b, 32'd254);
      if (i == 255) chk("sat_cnt_255", cnt_b, 32'd255);
    end
    chk("sat_cnt_hold", cnt_b, 32'd255);
    chk("sat_busy", busy_b, 32'd1);
    chk("sat_cycle_count", cyc_b, 32'd300);
    chk("sat_last_v0", last_v0_b, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
